// File: rtl/fir_cmd_sequencer_if.sv
// Handshake and SCIE command bundle for the FIR command sequencer.
// slave = sequencer side, master = environment side.
interface fir_cmd_sequencer_if;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_index;
  logic [15:0] cfg_real;
  logic [15:0] cfg_imag;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_real;
  logic [15:0] in_imag;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_real;
  logic [15:0] out_imag;
  logic        scie_valid;
  logic [31:0] scie_insn;
  logic [15:0] scie_rs1_real;
  logic [15:0] scie_rs1_imag;
  logic [31:0] scie_rs2;
  logic [15:0] scie_rd_real;
  logic [15:0] scie_rd_imag;
  logic        err_idx;
  logic        busy;

  modport slave (
    input  cfg_valid, cfg_index, cfg_real, cfg_imag,
    input  in_valid, in_real, in_imag, out_ready,
    input  scie_rd_real, scie_rd_imag,
    output cfg_ready, in_ready, out_valid,
    output out_real, out_imag,
    output scie_valid, scie_insn,
    output scie_rs1_real, scie_rs1_imag, scie_rs2,
    output err_idx, busy
  );

  modport master (
    output cfg_valid, cfg_index, cfg_real, cfg_imag,
    output in_valid, in_real, in_imag, out_ready,
    output scie_rd_real, scie_rd_imag,
    input  cfg_ready, in_ready, out_valid,
    input  out_real, out_imag,
    input  scie_valid, scie_insn,
    input  scie_rs1_real, scie_rs1_imag, scie_rs2,
    input  err_idx, busy
  );
endinterface

// File: rtl/fir_cmd_sequencer.sv
// Sequences coefficient loads and sample push/read commands to a SCIE
// FIR stage and queues the returned results in a small FIFO.
module fir_cmd_sequencer #(
  parameter int NTAPS     = 3,
  parameter int OUT_DEPTH = 4
) (
  input logic                clock,
  input logic                reset,
  fir_cmd_sequencer_if.slave bus
);
  localparam int AW = $clog2(OUT_DEPTH);
  localparam logic [AW:0] DEPTH = (AW+1)'(OUT_DEPTH);
  localparam logic [31:0] OP_LOAD = 32'd11;
  localparam logic [31:0] OP_PUSH = 32'd43;
  localparam logic [31:0] OP_READ = 32'd91;

  typedef enum logic [2:0] {
    IDLE, CFG, PUSH, GAP, READ, CAP
  } state_t;

  state_t state, state_nx;

  logic [15:0]   op_re, op_im;
  logic [1:0]    op_idx;
  logic [AW-1:0] head, tail;
  logic [AW:0]   count;
  logic [15:0]   mem_re [OUT_DEPTH];
  logic [15:0]   mem_im [OUT_DEPTH];
  logic          err_q;

  logic        idle, idx_ok;
  logic        cfg_rdy, in_rdy;
  logic        cfg_fire, in_fire;
  logic        out_vld, push, pop;
  logic        sv;
  logic [31:0] insn, rs2;
  logic [15:0] rs1_re, rs1_im;

  assign idle     = reset && (state == IDLE);
  assign idx_ok   = (32'(bus.cfg_index) < NTAPS);
  // cfg wins: a pending cfg masks in_ready
  assign cfg_rdy  = idle;
  assign in_rdy   = idle && !bus.cfg_valid
                    && (count < DEPTH);
  assign cfg_fire = bus.cfg_valid && cfg_rdy;
  assign in_fire  = bus.in_valid && in_rdy;
  assign out_vld  = reset && (count != '0);
  assign push     = reset && (state == CAP);
  assign pop      = out_vld && bus.out_ready;

  always_comb begin
    state_nx = state;
    sv       = 1'b0;
    insn     = '0;
    rs1_re   = '0;
    rs1_im   = '0;
    rs2      = '0;
    unique case (state)
      IDLE: begin
        unique case (1'b1)
          cfg_fire && idx_ok: state_nx = CFG;
          in_fire:            state_nx = PUSH;
          default:            state_nx = IDLE;
        endcase
      end
      CFG: begin
        sv       = 1'b1;
        insn     = OP_LOAD;
        rs1_re   = op_re;
        rs1_im   = op_im;
        rs2      = {30'd0, op_idx};
        state_nx = IDLE;
      end
      PUSH: begin
        sv       = 1'b1;
        insn     = OP_PUSH;
        rs1_re   = op_re;
        rs1_im   = op_im;
        state_nx = GAP;
      end
      GAP:  state_nx = READ;
      READ: begin
        sv       = 1'b1;
        insn     = OP_READ;
        state_nx = CAP;
      end
      CAP:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (!reset) begin
      sv     = 1'b0;
      insn   = '0;
      rs1_re = '0;
      rs1_im = '0;
      rs2    = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (cfg_fire && !idx_ok)
        err_q <= 1'b1;
      if (push)
        tail <= tail + 1'b1;
      if (pop)
        head <= head + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (cfg_fire) begin
      op_re  <= bus.cfg_real;
      op_im  <= bus.cfg_imag;
      op_idx <= bus.cfg_index;
    end else if (in_fire) begin
      op_re  <= bus.in_real;
      op_im  <= bus.in_imag;
    end
    if (push) begin
      mem_re[tail] <= bus.scie_rd_real;
      mem_im[tail] <= bus.scie_rd_imag;
    end
  end

  assign bus.cfg_ready     = cfg_rdy;
  assign bus.in_ready      = in_rdy;
  assign bus.out_valid     = out_vld;
  assign bus.out_real      = out_vld ? mem_re[head] : '0;
  assign bus.out_imag      = out_vld ? mem_im[head] : '0;
  assign bus.scie_valid    = sv;
  assign bus.scie_insn     = insn;
  assign bus.scie_rs1_real = rs1_re;
  assign bus.scie_rs1_imag = rs1_im;
  assign bus.scie_rs2      = rs2;
  assign bus.err_idx       = err_q;
  assign bus.busy          = reset && (state != IDLE);
endmodule

// File: tb/tb_fir_cmd_sequencer.sv
// Bench for fir_cmd_sequencer with a behavioural 3-tap complex FIR
// stage attached; results checked through a scoreboard queue.
module tb_fir_cmd_sequencer;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  fir_cmd_sequencer_if ifc ();

  fir_cmd_sequencer #(
    .NTAPS(3),
    .OUT_DEPTH(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(ifc.slave)
  );

  typedef struct { int re; int im; } cplx_t;
  typedef struct { int idx; int re; int im; } cmd_t;

  cplx_t exp_q[$];
  cmd_t  cmd_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string nm,
                       input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out, got no handshake, expected one", nm);
  endtask

  // FIR stage: newest sample in x[0]; result returned one cycle after READ
  int cr[3], ci[3], xr[3], xi[3];
  int pr, pi;
  logic rd_go = 1'b0;
  logic [15:0] rd_re = 16'h7bad;
  logic [15:0] rd_im = 16'h7bad;
  assign ifc.scie_rd_real = rd_re;
  assign ifc.scie_rd_imag = rd_im;

  always @(negedge clock) begin
    rd_go = 1'b0;
    if (ifc.scie_valid) begin
      if (ifc.scie_insn == 32'd11 && ifc.scie_rs2 < 32'd3) begin
        cr[ifc.scie_rs2[1:0]] = int'($signed(ifc.scie_rs1_real));
        ci[ifc.scie_rs2[1:0]] = int'($signed(ifc.scie_rs1_imag));
      end else if (ifc.scie_insn == 32'd43) begin
        xr[2] = xr[1]; xr[1] = xr[0];
        xi[2] = xi[1]; xi[1] = xi[0];
        xr[0] = int'($signed(ifc.scie_rs1_real));
        xi[0] = int'($signed(ifc.scie_rs1_imag));
      end else if (ifc.scie_insn == 32'd91) begin
        pr = 0;
        pi = 0;
        for (int k = 0; k < 3; k++) begin
          pr += cr[k] * xr[k] - ci[k] * xi[k];
          pi += cr[k] * xi[k] + ci[k] * xr[k];
        end
        rd_go = 1'b1;
      end
    end
  end

  always @(posedge clock) begin
    if (rd_go) begin
      rd_re <= pr[15:0];
      rd_im <= pi[15:0];
    end else begin
      rd_re <= 16'h7bad;
      rd_im <= 16'h7bad;
    end
  end

  cplx_t eo;
  always @(negedge clock) begin
    if (reset && ifc.out_valid && ifc.out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL out_unexpected: got %0d,%0d, expected none",
                 $signed(ifc.out_real), $signed(ifc.out_imag));
      end else begin
        eo = exp_q.pop_front();
        check("out_real", $signed(ifc.out_real), eo.re);
        check("out_imag", $signed(ifc.out_imag), eo.im);
      end
    end
  end

  cmd_t ec;
  always @(negedge clock) begin
    if (ifc.scie_valid && ifc.scie_insn == 32'd11) begin
      if (cmd_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL cfg_cmd_unexpected: got rs2 %0d, expected none",
                 ifc.scie_rs2);
      end else begin
        ec = cmd_q.pop_front();
        check("cfg_rs2", ifc.scie_rs2, ec.idx);
        check("cfg_rs1_real", $signed(ifc.scie_rs1_real), ec.re);
        check("cfg_rs1_imag", $signed(ifc.scie_rs1_imag), ec.im);
      end
    end else if (!ifc.scie_valid) begin
      check("scie_idle_zero",
            32'(|{ifc.scie_insn, ifc.scie_rs1_real,
                  ifc.scie_rs1_imag, ifc.scie_rs2}), 0);
    end
  end

  task automatic do_cfg(input int idx, input int re, input int im);
    cmd_t c;
    ifc.cfg_valid = 1'b1;
    ifc.cfg_index = 2'(idx);
    ifc.cfg_real  = 16'(re);
    ifc.cfg_imag  = 16'(im);
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (ifc.cfg_ready) begin
        if (idx < 3) begin
          c.idx = idx; c.re = re; c.im = im;
          cmd_q.push_back(c);
        end
        @(posedge clock);
        #1 ifc.cfg_valid = 1'b0;
        return;
      end
    end
    timeout("cfg_accept");
    ifc.cfg_valid = 1'b0;
  endtask

  task automatic do_sample(input int re, input int im,
                           input bit expect_out,
                           input int ere, input int eim,
                           output int acc);
    cplx_t e;
    acc = -1;
    ifc.in_valid = 1'b1;
    ifc.in_real  = 16'(re);
    ifc.in_imag  = 16'(im);
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (ifc.in_ready) begin
        acc = cyc;
        if (expect_out) begin
          e.re = ere; e.im = eim;
          exp_q.push_back(e);
        end
        @(posedge clock);
        #1 ifc.in_valid = 1'b0;
        return;
      end
    end
    timeout("sample_accept");
    ifc.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      if (exp_q.size() == 0) begin
        @(posedge clock);
        #1;
        return;
      end
    end
    timeout("fifo_drain");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  int a0, a1, a2, lat;
  bit seen;

  initial begin
    ifc.cfg_valid = 1'b0;
    ifc.cfg_index = '0;
    ifc.cfg_real  = '0;
    ifc.cfg_imag  = '0;
    ifc.in_valid  = 1'b0;
    ifc.in_real   = '0;
    ifc.in_imag   = '0;
    ifc.out_ready = 1'b0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_busy", ifc.busy, 0);
    check("rst_out_valid", ifc.out_valid, 0);
    check("rst_cfg_ready", ifc.cfg_ready, 0);
    check("rst_in_ready", ifc.in_ready, 0);
    check("rst_scie_valid", ifc.scie_valid, 0);
    check("rst_out_real", ifc.out_real, 0);
    check("rst_err_idx", ifc.err_idx, 0);
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    check("idle_cfg_ready", ifc.cfg_ready, 1);
    check("idle_in_ready", ifc.in_ready, 1);
    @(posedge clock);
    #1;

    // coefficient load then first sample
    ifc.out_ready = 1'b1;
    do_cfg(0, 29, 9);
    do_cfg(1, -1, 36);
    do_cfg(2, -15, 32);
    do_sample(-4, 30, 1'b1, -386, 834, a0);
    @(negedge clock);
    check("busy_push", ifc.busy, 1);
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      if (ifc.out_valid) begin
        lat = cyc - a0;
        break;
      end
      @(negedge clock);
    end
    n_cmp++;
    if (lat < 5 || lat > 6) begin
      n_bad++;
      $display("FAIL first_latency: got %0d, expected 5..6", lat);
    end
    wait_drain();

    do_sample(-5, 9, 1'b1, -1302, 42, a1);
    do_sample(-28, -44, 1'b1, -1635, -2295, a2);
    check("accept_spacing", a2 - a1, 5);
    wait_drain();

    // identity filter, then fill FIFO with out_ready low
    do_cfg(0, 1, 0);
    do_cfg(1, 0, 0);
    do_cfg(2, 0, 0);
    ifc.out_ready = 1'b0;
    for (int k = 0; k < 4; k++)
      do_sample(100 + k, -200 - k, 1'b1, 100 + k, -200 - k, a0);
    ifc.in_valid = 1'b1;
    ifc.in_real  = 16'(104);
    ifc.in_imag  = 16'(-204);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      seen |= ifc.in_ready;
    end
    check("full_in_ready", 32'(seen), 0);
    check("full_out_valid", ifc.out_valid, 1);
    check("hold_out_real", $signed(ifc.out_real), 100);
    check("hold_out_imag", $signed(ifc.out_imag), -200);
    @(posedge clock);
    #1 ifc.out_ready = 1'b1;
    do_sample(104, -204, 1'b1, 104, -204, a0);
    wait_drain();

    // bad index together with a sample
    ifc.cfg_valid = 1'b1;
    ifc.cfg_index = 2'd3;
    ifc.cfg_real  = 16'(5);
    ifc.cfg_imag  = 16'(6);
    ifc.in_valid  = 1'b1;
    ifc.in_real   = 16'(7);
    ifc.in_imag   = 16'(-8);
    @(negedge clock);
    check("both_cfg_ready", ifc.cfg_ready, 1);
    check("both_in_ready", ifc.in_ready, 0);
    check("both_scie_valid", ifc.scie_valid, 0);
    @(posedge clock);
    #1 ifc.cfg_valid = 1'b0;
    @(negedge clock);
    check("err_idx_set", ifc.err_idx, 1);
    check("err_scie_valid", ifc.scie_valid, 0);
    check("err_in_ready", ifc.in_ready, 1);
    if (ifc.in_ready) begin
      eo.re = 7; eo.im = -8;
      exp_q.push_back(eo);
    end
    @(posedge clock);
    #1 ifc.in_valid = 1'b0;
    @(negedge clock);
    check("err_push_insn", ifc.scie_insn, 43);
    check("err_push_rs1", $signed(ifc.scie_rs1_real), 7);
    wait_drain();

    // reset during GAP aborts the sample
    check("err_idx_sticky", ifc.err_idx, 1);
    do_sample(55, 66, 1'b0, 0, 0, a0);
    @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    check("abort_busy", ifc.busy, 0);
    check("abort_out_valid", ifc.out_valid, 0);
    check("abort_err_clr", ifc.err_idx, 0);
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      seen |= ifc.out_valid;
    end
    check("abort_no_write", 32'(seen), 0);
    @(posedge clock);
    #1;
    do_sample(77, 88, 1'b1, 77, 88, a0);
    wait_drain();

    check("exp_q_left", exp_q.size(), 0);
    check("cmd_q_left", cmd_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
